poly_eval_seq: RTL and testbench

- Parametrised sequential polynomial evaluator: y = a_N*x^N + ... + a_1*x + a_0 mod 2^DATA_W, computed by Horner's rule, one multiply-add per clock.
- Coefficients and x are entered one word at a time over a shared data_in bus with a load strobe (board KEY/SW front end or a bus master).
- Generalises the fixed-degree, fixed-width datapath/control evaluator: width and degree are parameters, a done/busy handshake is added, and a coefficient-reuse mode allows successive x values to be evaluated without reloading coefficients.

---
 rtl/poly_eval_seq.sv | 204 ++++++++++++++++++++
 tb/tb_poly_eval_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_seq.sv
// rtl/poly_eval_seq.sv - sequential Horner-rule polynomial evaluator
//
// Evaluates y = a_N*x^N + ... + a_1*x + a_0 mod 2^DATA_W with one multiply-add
// per clock. Coefficients (a_N first) and then x are entered one word per load
// strobe on data_in. With keep_coef=1 in the final compute cycle the stored
// coefficients are reused and only a new x is expected.
//
// Optional feature macro: POLY_OVF_FLAG_EN (adds the sticky overflow output).
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   coefficient or x word (DATA_W)
//   load        in   capture data_in this cycle; ignored while busy
//   keep_coef   in   sampled in the final compute cycle; 1 = reuse coefficients
//   load_ready  out  1 while a coefficient or x word can be loaded
//   busy        out  1 while computing
//   expect_x    out  1 while the next load is taken as x
//   done        out  one-cycle pulse when data_result is updated
//   data_result out  last result, held until the next done or reset (DATA_W)
//   overflow    out  (POLY_OVF_FLAG_EN only) some intermediate t exceeded DATA_W bits

module poly_eval_seq #(
    parameter int DATA_W = 8,
    parameter int DEGREE = 3,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    input  logic              keep_coef,
    output logic              load_ready,
    output logic              busy,
    output logic              expect_x,
    output logic              done,
`ifdef POLY_OVF_FLAG_EN
    output logic              overflow,
`endif
    output logic [DATA_W-1:0] data_result
);

    typedef enum logic [1:0] {
        S_LOAD_COEF = 2'd0,
        S_LOAD_X    = 2'd1,
        S_COMPUTE   = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] coef [0:DEGREE];
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] acc;
    logic [IDX_W-1:0]  idx;

    // Control strobes decoded by the FSM for the datapath
    logic cap_coef;
    logic cap_x;
    logic step;
    logic last_step;

    // coef[idx], selected by comparison so the index width never has to match
    // the array depth
    logic [DATA_W-1:0] coef_sel;

    always_comb begin
        coef_sel = '0;
        for (int i = 0; i <= DEGREE; i++) begin
            if (idx == IDX_W'(i)) begin
                coef_sel = coef[i];
            end
        end
    end

    // Horner step. Only the low DATA_W bits are architecturally kept; the
    // overflow build needs the full 2*DATA_W+1 bit sum to see any carry out.
    logic [DATA_W-1:0] t_lo;
`ifdef POLY_OVF_FLAG_EN
    localparam int T_W = 2 * DATA_W + 1;
    logic [T_W-1:0]    t_full;
    logic              t_big;

    always_comb begin
        t_full = T_W'(acc) * T_W'(x) + T_W'(coef_sel);
        t_lo   = t_full[DATA_W-1:0];
        t_big  = |t_full[T_W-1:DATA_W];
    end
`else
    always_comb begin
        t_lo = acc * x + coef_sel;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD_COEF;
        end else begin
            state <= next_state;
        end
    end

    // Next state, status outputs and datapath strobes
    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        expect_x   = 1'b0;
        cap_coef   = 1'b0;
        cap_x      = 1'b0;
        step       = 1'b0;
        last_step  = 1'b0;
        case (state)
            S_LOAD_COEF: begin
                load_ready = 1'b1;
                if (load) begin
                    cap_coef = 1'b1;
                    if (idx == '0) begin
                        next_state = S_LOAD_X;
                    end
                end
            end
            S_LOAD_X: begin
                load_ready = 1'b1;
                expect_x   = 1'b1;
                if (load) begin
                    cap_x      = 1'b1;
                    next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                // load is deliberately not looked at here: it is dropped
                busy = 1'b1;
                step = 1'b1;
                if (idx == '0) begin
                    last_step  = 1'b1;
                    next_state = keep_coef ? S_LOAD_X : S_LOAD_COEF;
                end
            end
            default: begin
                next_state = S_LOAD_COEF;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i <= DEGREE; i++) begin
                coef[i] <= '0;
            end
            x           <= '0;
            acc         <= '0;
            idx         <= IDX_W'(DEGREE);
            data_result <= '0;
            done        <= 1'b0;
`ifdef POLY_OVF_FLAG_EN
            overflow    <= 1'b0;
`endif
        end else begin
            done <= last_step;

            if (cap_coef) begin
                for (int i = 0; i <= DEGREE; i++) begin
                    if (idx == IDX_W'(i)) begin
                        coef[i] <= data_in;
                    end
                end
                // idx stays at 0 after a_0; the x capture reloads it anyway
                if (idx != '0) begin
                    idx <= idx - 1'b1;
                end
            end

            if (cap_x) begin
                x   <= data_in;
                acc <= coef[DEGREE];
                idx <= IDX_W'(DEGREE - 1);
`ifdef POLY_OVF_FLAG_EN
                overflow <= 1'b0;
`endif
            end

            if (step) begin
                acc <= t_lo;
`ifdef POLY_OVF_FLAG_EN
                if (t_big) begin
                    overflow <= 1'b1;
                end
`endif
                if (last_step) begin
                    data_result <= t_lo;
                    // Ready for a fresh coefficient load; when coefficients
                    // are kept, the x capture overwrites idx before use
                    idx         <= IDX_W'(DEGREE);
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_poly_eval_seq.sv
// tb/tb_poly_eval_seq.sv - scoreboard bench for poly_eval_seq (8-bit deg 3 and 16-bit deg 1)

module tb_poly_eval_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic reset;

    // 8-bit, degree-3 instance
    logic [7:0]  data_in8;
    logic        load8, keep8;
    logic        load_ready8, busy8, expect_x8, done8;
    logic [7:0]  res8;
    logic        ovf8;

    // 16-bit, degree-1 instance
    logic [15:0] data_in16;
    logic        load16, keep16;
    logic        load_ready16, busy16, expect_x16, done16;
    logic [15:0] res16;
    logic        ovf16;

    poly_eval_seq #(.DATA_W(8), .DEGREE(3), .IDX_W(4)) u8 (
        .clk(clk), .reset(reset), .data_in(data_in8), .load(load8),
        .keep_coef(keep8), .load_ready(load_ready8), .busy(busy8),
        .expect_x(expect_x8), .done(done8),
`ifdef POLY_OVF_FLAG_EN
        .overflow(ovf8),
`endif
        .data_result(res8)
    );

    poly_eval_seq #(.DATA_W(16), .DEGREE(1), .IDX_W(1)) u16 (
        .clk(clk), .reset(reset), .data_in(data_in16), .load(load16),
        .keep_coef(keep16), .load_ready(load_ready16), .busy(busy16),
        .expect_x(expect_x16), .done(done16),
`ifdef POLY_OVF_FLAG_EN
        .overflow(ovf16),
`endif
        .data_result(res16)
    );

`ifndef POLY_OVF_FLAG_EN
    assign ovf8  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t m8, m16;

    // Monitors: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            chk("done8_pending", 32'(q8.size() > 0), 1);
            if (q8.size() > 0) begin
                m8 = q8.pop_front();
                chk("result8", 32'(res8), m8.res);
                chk("latency8", 32'(cyc), 32'(m8.at));
`ifdef POLY_OVF_FLAG_EN
                chk("overflow8", 32'(ovf8), 32'(m8.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            chk("done16_pending", 32'(q16.size() > 0), 1);
            if (q16.size() > 0) begin
                m16 = q16.pop_front();
                chk("result16", 32'(res16), m16.res);
                chk("latency16", 32'(cyc), 32'(m16.at));
`ifdef POLY_OVF_FLAG_EN
                chk("overflow16", 32'(ovf16), 32'(m16.ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word8(input logic [7:0] d);
        data_in8 = d;
        load8    = 1'b1;
        tick();
        load8    = 1'b0;
    endtask

    task automatic load_coefs8(input logic [7:0] a3, input logic [7:0] a2,
                               input logic [7:0] a1, input logic [7:0] a0);
        load_word8(a3);
        load_word8(a2);
        load_word8(a1);
        load_word8(a0);
    endtask

    task automatic wait_done8();
        int k;
        k = 0;
        while (done8 !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk("done8_seen", 32'(done8), 1);
    endtask

    // Load x, expecting 'res'; optionally hammer load=0xFF during compute
    task automatic eval8(input logic [7:0] xv, input logic [7:0] res,
                         input logic ovf, input logic keep, input logic busy_load);
        exp_t e;
        chk("expect_x8_before_x", 32'(expect_x8), 1);
        keep8 = keep;
        e.res = 32'(res);
        e.ovf = ovf;
        e.at  = cyc + 1 + 3;
        q8.push_back(e);
        load_word8(xv);
        if (busy_load) begin
            data_in8 = 8'hFF;
            load8    = 1'b1;
            tick();
            chk("busy8_during_compute", 32'(busy8), 1);
            tick();
            tick();
            load8 = 1'b0;
        end
        wait_done8();
    endtask

    task automatic load_word16(input logic [15:0] d);
        data_in16 = d;
        load16    = 1'b1;
        tick();
        load16    = 1'b0;
    endtask

    task automatic eval16(input logic [15:0] xv, input logic [15:0] res,
                          input logic ovf, input logic keep);
        exp_t e;
        int k;
        chk("expect_x16_before_x", 32'(expect_x16), 1);
        keep16 = keep;
        e.res  = 32'(res);
        e.ovf  = ovf;
        e.at   = cyc + 1 + 1;
        q16.push_back(e);
        load_word16(xv);
        k = 0;
        while (done16 !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        chk("done16_seen", 32'(done16), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        data_in8  = '0;
        load8     = 1'b0;
        keep8     = 1'b0;
        data_in16 = '0;
        load16    = 1'b0;
        keep16    = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_load_ready", 32'(load_ready8), 1);
        chk("rst_busy", 32'(busy8), 0);
        chk("rst_expect_x", 32'(expect_x8), 0);
        chk("rst_done", 32'(done8), 0);
        chk("rst_result", 32'(res8), 0);
`ifdef POLY_OVF_FLAG_EN
        chk("rst_overflow", 32'(ovf8), 0);
`endif

        // Basic: 1x^3+2x^2+3x+4 at x=2 -> 26
        load_coefs8(8'd1, 8'd2, 8'd3, 8'd4);
        eval8(8'd2, 8'h1A, 1'b0, 1'b1, 1'b0);
        chk("reuse_expect_x", 32'(expect_x8), 1);

        // Reuse, back-to-back on the done cycle: x=3 -> 58
        eval8(8'd3, 8'h3A, 1'b0, 1'b1, 1'b0);

        // Load while busy is dropped; result stays 0x1A
        eval8(8'd2, 8'h1A, 1'b0, 1'b1, 1'b1);
        // Coefficients intact after the busy loads
        eval8(8'd3, 8'h3A, 1'b0, 1'b0, 1'b0);
        chk("back_to_coef_load_ready", 32'(load_ready8), 1);
        chk("back_to_coef_expect_x", 32'(expect_x8), 0);
        tick();
        tick();
        tick();
        chk("result_held", 32'(res8), 32'h3A);

        // Wrap-around: x^3 at 16 -> 4096 mod 256 = 0, then x=2 -> 8
        load_coefs8(8'd1, 8'd0, 8'd0, 8'd0);
        eval8(8'd16, 8'h00, 1'b1, 1'b1, 1'b0);
        eval8(8'd2, 8'h08, 1'b0, 1'b0, 1'b0);

        // Reset on the second compute cycle: no done, result cleared
        load_coefs8(8'd1, 8'd2, 8'd3, 8'd4);
        load_word8(8'd2);
        tick();
        chk("midrst_busy", 32'(busy8), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_result", 32'(res8), 0);
        chk("midrst_load_ready", 32'(load_ready8), 1);
        chk("midrst_busy_after", 32'(busy8), 0);
        repeat (5) tick();
        // First word after reset must land in a_3: 5x^3+1 at 2 -> 41
        load_coefs8(8'd5, 8'd0, 8'd0, 8'd1);
        eval8(8'd2, 8'h29, 1'b0, 1'b0, 1'b0);

        // DEGREE=1, DATA_W=16: 0x100*0x100+1 = 0x10001 -> 0x0001
        load_word16(16'h0100);
        load_word16(16'h0001);
        eval16(16'h0100, 16'h0001, 1'b1, 1'b1);
        eval16(16'h0003, 16'h0301, 1'b0, 1'b0);

        repeat (4) tick();
        chk("q8_drained", 32'(q8.size()), 0);
        chk("q16_drained", 32'(q16.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
